// File: rtl/pipeline_control_unit.sv
// ----------------------------------------------------------------------------
// pipeline_control_unit
//   Run/stop sequencing, load-use hazard stalls, branch flushes, halt drain and
//   operand forwarding selects for a 5-stage in-order pipeline.
//
// Ports
//   clock, reset        : single clock, synchronous active-high reset
//   exec                : start/stop request level (rising edge acts)
//   halt_id, branch_id  : HLT decoded / taken branch resolved in ID
//   rs_id, rd_id        : ID source addresses, qualified by use_rs_id/use_rd_id
//   mem_read_ex, reg_write_ex, dst_ex : EX-stage load / write / destination
//   reg_write_mem/wb, dst_mem/wb      : later-stage write flags / destinations
//   pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble : controls
//   fwd_a, fwd_b        : 00 regfile, 01 MEM result, 10 WB result
//   running             : high in RUN and STALL
//   stall_count         : saturating count of bubble cycles while running
// ----------------------------------------------------------------------------

// Forwarding select for one operand; MEM has the younger value so it wins.
module pcu_fwd_sel #(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              reg_write_mem_i,
  input  logic [REG_AW-1:0] dst_mem_i,
  input  logic              reg_write_wb_i,
  input  logic [REG_AW-1:0] dst_wb_i,
  output logic [1:0]        sel_o
);
  always_comb begin
    sel_o = 2'b00;
    if (reg_write_mem_i && dst_mem_i == src_i)     sel_o = 2'b01;
    else if (reg_write_wb_i && dst_wb_i == src_i)  sel_o = 2'b10;
  end
endmodule

module pipeline_control_unit #(
  parameter int REG_AW       = 3,
  parameter int LOAD_STALL   = 1,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  input  logic              halt_id,
  input  logic              branch_id,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              use_rs_id,
  input  logic              use_rd_id,
  input  logic              mem_read_ex,
  input  logic              reg_write_ex,
  input  logic [REG_AW-1:0] dst_ex,
  input  logic              reg_write_mem,
  input  logic              reg_write_wb,
  input  logic [REG_AW-1:0] dst_mem,
  input  logic [REG_AW-1:0] dst_wb,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              running,
  output logic [15:0]       stall_count
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STALL, S_DRAIN, S_HALTED} state_e;

  localparam logic [2:0] LS_M1 = 3'(LOAD_STALL - 1);
  localparam logic [2:0] DR_M1 = 3'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        dest_halt_q, dest_halt_d;   // 1: drain ends in HALTED, 0: IDLE
  logic        exec_q;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic exec_edge, hazard;

  assign exec_edge = exec & ~exec_q;
  assign hazard    = mem_read_ex & reg_write_ex &
                     ((use_rs_id & (rs_id == dst_ex)) | (use_rd_id & (rd_id == dst_ex)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dest_halt_q <= 1'b0;
      exec_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dest_halt_q <= dest_halt_d;
      exec_q      <= exec;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dest_halt_d  = dest_halt_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b0;
    id_ex_bubble = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (exec_edge) state_d = S_RUN;
      end
      S_RUN: begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        id_ex_write = 1'b1;
        // Priority: stop request > load-use hazard > halt > branch.
        if (exec_edge) begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          state_d     = S_DRAIN;
          cnt_d       = DR_M1;
          dest_halt_d = 1'b0;
        end else if (hazard) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          // This cycle is the first bubble; STALL covers the remainder.
          if (LS_M1 != 3'd0) begin
            state_d = S_STALL;
            cnt_d   = LS_M1;
          end
        end else if (halt_id) begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          state_d     = S_DRAIN;
          cnt_d       = DR_M1;
          dest_halt_d = 1'b1;
        end else if (branch_id) begin
          if_id_flush = 1'b1;
        end
      end
      S_STALL: begin
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b1;
        if (exec_edge) begin
          state_d     = S_DRAIN;
          cnt_d       = DR_M1;
          dest_halt_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // exec edges are deliberately not looked at here.
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b1;
        if (cnt_q == 3'd0) state_d = dest_halt_q ? S_HALTED : S_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign running = (state_q == S_RUN) || (state_q == S_STALL);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_ex_bubble && running && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  assign stall_count = stall_cnt_q;

  // Operand forwarding: index 0 -> A (rs_id), index 1 -> B (rd_id).
  logic [1:0][REG_AW-1:0] fwd_src;
  logic [1:0][1:0]        fwd_sel;

  assign fwd_src[0] = rs_id;
  assign fwd_src[1] = rd_id;

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    pcu_fwd_sel #(.REG_AW(REG_AW)) u_sel (
      .src_i           (fwd_src[g]),
      .reg_write_mem_i (reg_write_mem),
      .dst_mem_i       (dst_mem),
      .reg_write_wb_i  (reg_write_wb),
      .dst_wb_i        (dst_wb),
      .sel_o           (fwd_sel[g])
    );
  end

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];

endmodule

// File: tb/tb_pipeline_control_unit.sv
module tb_pipeline_control_unit;
  localparam int AW = 3;

  logic clock = 1'b0;
  logic reset, exec, halt_id, branch_id, use_rs_id, use_rd_id;
  logic mem_read_ex, reg_write_ex, reg_write_mem, reg_write_wb;
  logic [AW-1:0] rs_id, rd_id, dst_ex, dst_mem, dst_wb;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, running;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_count;

  always #5 clock = ~clock;

  pipeline_control_unit #(.REG_AW(AW), .LOAD_STALL(2), .DRAIN_CYCLES(3)) dut (
    .clock(clock), .reset(reset), .exec(exec), .halt_id(halt_id), .branch_id(branch_id),
    .rs_id(rs_id), .rd_id(rd_id), .use_rs_id(use_rs_id), .use_rd_id(use_rd_id),
    .mem_read_ex(mem_read_ex), .reg_write_ex(reg_write_ex), .dst_ex(dst_ex),
    .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
    .dst_mem(dst_mem), .dst_wb(dst_wb),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .running(running), .stall_count(stall_count)
  );

  typedef struct packed {
    logic pcw, ifw, fl, idw, bub;
    logic [1:0] fa, fb;
    logic run;
    logic [15:0] sc;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int total = 0;
  int bad   = 0;

  function automatic exp_t mk(logic pcw, logic ifw, logic fl, logic idw, logic bub,
                              logic [1:0] fa, logic [1:0] fb, logic run, logic [15:0] sc);
    exp_t e;
    e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.idw = idw; e.bub = bub;
    e.fa = fa; e.fb = fb; e.run = run; e.sc = sc;
    return e;
  endfunction

  // Common expectation shapes
  function automatic exp_t e_off(logic [15:0] sc);   return mk(0,0,0,0,0,2'b00,2'b00,0,sc); endfunction
  function automatic exp_t e_run(logic [15:0] sc);   return mk(1,1,0,1,0,2'b00,2'b00,1,sc); endfunction
  function automatic exp_t e_bub(logic [15:0] sc);   return mk(0,0,0,1,1,2'b00,2'b00,1,sc); endfunction
  function automatic exp_t e_drain(logic [15:0] sc); return mk(0,0,0,1,1,2'b00,2'b00,0,sc); endfunction
  function automatic exp_t e_stop(logic [15:0] sc);  return mk(0,1,1,1,0,2'b00,2'b00,1,sc); endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic clr();
    halt_id = 0; branch_id = 0; use_rs_id = 0; use_rd_id = 0;
    mem_read_ex = 0; reg_write_ex = 0; reg_write_mem = 0; reg_write_wb = 0;
    rs_id = '0; rd_id = '0; dst_ex = '0; dst_mem = '0; dst_wb = '0;
  endtask

  // Push the expectation for the current cycle, then pop and compare it
  // against the DUT outputs at the falling edge.
  task automatic check(input string tag, input exp_t e);
    exp_t  ex, obs;
    string t;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clock);
    ex = sb_q.pop_front();
    t  = tag_q.pop_front();
    obs = mk(pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
             fwd_a, fwd_b, running, stall_count);
    total++;
    assert (obs === ex) else begin
      bad++;
      $error("FAIL %s: observed pcw/ifw/fl/idw/bub/fa/fb/run/sc=%b%b%b%b%b/%b/%b/%b/%h expected %b%b%b%b%b/%b/%b/%b/%h",
             t, obs.pcw, obs.ifw, obs.fl, obs.idw, obs.bub, obs.fa, obs.fb, obs.run, obs.sc,
             ex.pcw, ex.ifw, ex.fl, ex.idw, ex.bub, ex.fa, ex.fb, ex.run, ex.sc);
    end
  endtask

  task automatic set_haz_rs3();
    mem_read_ex = 1; reg_write_ex = 1; dst_ex = 3'd3; rs_id = 3'd3; use_rs_id = 1;
  endtask

  initial begin
    clr();
    reset = 1; exec = 1;               // reset must win over exec
    tick();                 check("reset", e_off(0));
    reset = 0; exec = 0;    check("idle", e_off(0));
    tick(); exec = 1;       check("idle_edge", e_off(0));
    tick();                 check("run_start", e_run(0));

    // Load-use hazard with a simultaneous branch: two bubbles, then flush.
    tick(); set_haz_rs3(); branch_id = 1;
                            check("haz_rs", e_bub(0));
    tick(); mem_read_ex = 0; check("stall", e_bub(1));
    tick();                 check("branch_after_stall", mk(1,1,1,1,0,2'b00,2'b00,1,2));
    tick(); clr();          check("run_plain", e_run(2));

    // Load without write-back is not a hazard.
    tick(); mem_read_ex = 1; dst_ex = 3'd3; rs_id = 3'd3; use_rs_id = 1;
                            check("nohaz_rw0", e_run(2));
    // Hazard via rd only.
    tick(); clr(); mem_read_ex = 1; reg_write_ex = 1; dst_ex = 3'd6; rd_id = 3'd6; use_rd_id = 1;
                            check("haz_rd", e_bub(2));
    tick(); clr();          check("stall_rd", e_bub(3));
    tick();                 check("run_after_rd", e_run(4));

    // Forwarding priority.
    tick(); reg_write_mem = 1; dst_mem = 3'd2; reg_write_wb = 1; dst_wb = 3'd2; rs_id = 3'd2; rd_id = 3'd5;
                            check("fwd_mem", mk(1,1,0,1,0,2'b01,2'b00,1,4));
    tick(); reg_write_mem = 0; rd_id = 3'd2;
                            check("fwd_wb", mk(1,1,0,1,0,2'b10,2'b10,1,4));

    // Halt: three drain cycles (exec edge inside drain ignored), then HALTED.
    tick(); clr(); halt_id = 1; check("halt", e_stop(4));
    tick(); clr(); exec = 0; check("drain1", e_drain(4));
    tick(); exec = 1;       check("drain2", e_drain(4));
    tick();                 check("drain3", e_drain(4));
    tick();                 check("halted", e_off(4));
    tick(); exec = 0;       check("halted_hold", e_off(4));
    tick(); exec = 1;       check("halted_edge", e_off(4));
    tick();                 check("run_from_halt", e_run(4));

    // Stop request outranks halt and hazard; drains back to IDLE.
    tick(); exec = 0;       check("run_pre_stop", e_run(4));
    tick(); exec = 1; halt_id = 1; set_haz_rs3();
                            check("stop_edge", e_stop(4));
    tick(); clr();          check("sdrain1", e_drain(4));
    tick();                 check("sdrain2", e_drain(4));
    tick();                 check("sdrain3", e_drain(4));
    tick();                 check("idle_after_stop", e_off(4));
    tick(); exec = 0;       check("idle2", e_off(4));
    tick(); exec = 1;       check("idle2_edge", e_off(4));
    tick();                 check("run_restart", e_run(4));

    // Reset in the middle of a drain.
    tick(); set_haz_rs3();  check("haz3", e_bub(4));
    tick(); clr();          check("stall3", e_bub(5));
    tick(); halt_id = 1;    check("halt2", e_stop(6));
    tick(); clr();          check("rdrain1", e_drain(6));
    tick(); reset = 1; exec = 0; check("rdrain2", e_drain(6));
    tick(); reset = 0;      check("rst_mid_drain", e_off(0));
    tick(); exec = 1;       check("rst_idle_edge", e_off(0));
    tick();                 check("run_after_rst", e_run(0));

    // Saturation: keep the hazard asserted so every running cycle bubbles.
    tick(); set_haz_rs3();
    repeat (65540) tick();
    clr();
    tick();
    tick();                 check("sat", e_run(16'hFFFF));
    tick();                 check("sat_hold", e_run(16'hFFFF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
